// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong score controller.
package pong_pkg;

  localparam int unsigned WIN_SCORE_DEF   = 11;
  localparam int unsigned SERVE_DELAY_DEF = 50_000_000;
  localparam int unsigned SCORE_W         = 7;
  localparam int unsigned TIMER_W         = 26;
  localparam int unsigned INC_W           = 2;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    OVER
  } state_t;

  typedef enum logic [INC_W-1:0] {
    INC_NONE  = 2'b00,
    INC_LEFT  = 2'b01,
    INC_RIGHT = 2'b10
  } inc_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; the history register's reset value is a parameter
// so a level held through reset can be treated as already seen.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic prev;

  // Previous-value history register.
  always_ff @(posedge clk) begin
    if (reset) prev <= RESET_VAL;
    else       prev <= d;
  end

  assign rise_c = d & ~prev;

endmodule

// File: rtl/pong_score_ctrl.sv
// Game flow and scoring controller for pong: serve timing, point
// crediting, win detection and pulses to the downstream score counter.
module pong_score_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             miss_left,
  input  logic             miss_right,
  output logic [INC_W-1:0] d_inc,
  output logic             d_clr,
  output logic             ball_reset,
  output logic             game_over,
  output logic [INC_W-1:0] winner
);

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] score_left, score_left_nxt;
  logic [SCORE_W-1:0] score_right, score_right_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [INC_W-1:0]   d_inc_nxt, winner_nxt;
  logic               d_clr_nxt, ball_reset_nxt, game_over_nxt;
  logic               start_rise_c;
  logic               won_c;

  // A button held through reset must not count as a fresh press.
  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .clk    (clk),
    .reset  (reset),
    .d      (btn_start),
    .rise_c (start_rise_c)
  );

  // In POINT, d_inc still carries the credited side; its score is already bumped.
  assign won_c = ((d_inc == INC_LEFT)  && (score_left  == SCORE_W'(WIN_SCORE))) ||
                 ((d_inc == INC_RIGHT) && (score_right == SCORE_W'(WIN_SCORE)));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt       = state;
    score_left_nxt  = score_left;
    score_right_nxt = score_right;
    timer_nxt       = '0;
    d_inc_nxt       = INC_NONE;
    d_clr_nxt       = 1'b0;
    winner_nxt      = winner;

    case (state)
      IDLE: begin
        if (start_rise_c) begin
          d_clr_nxt       = 1'b1;
          score_left_nxt  = '0;
          score_right_nxt = '0;
          state_nxt       = SERVE;
        end
      end
      SERVE: begin
        timer_nxt = timer + TIMER_W'(1);
        if (timer == TIMER_W'(SERVE_DELAY - 1)) state_nxt = PLAY;
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          state_nxt = SERVE;
        end else if (miss_right) begin
          d_inc_nxt      = INC_LEFT;
          score_left_nxt = score_left + SCORE_W'(1);
          state_nxt      = POINT;
        end else if (miss_left) begin
          d_inc_nxt       = INC_RIGHT;
          score_right_nxt = score_right + SCORE_W'(1);
          state_nxt       = POINT;
        end
      end
      POINT: begin
        if (won_c) begin
          winner_nxt = d_inc;
          state_nxt  = OVER;
        end else begin
          state_nxt = SERVE;
        end
      end
      OVER: begin
        if (start_rise_c) begin
          d_clr_nxt       = 1'b1;
          score_left_nxt  = '0;
          score_right_nxt = '0;
          winner_nxt      = INC_NONE;
          state_nxt       = SERVE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ball_reset_nxt = (state_nxt != PLAY);
    game_over_nxt  = (state_nxt == OVER);
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_left  <= '0;
      score_right <= '0;
      timer       <= '0;
      d_inc       <= INC_NONE;
      d_clr       <= 1'b0;
      ball_reset  <= 1'b1;
      game_over   <= 1'b0;
      winner      <= INC_NONE;
    end else begin
      score_left  <= score_left_nxt;
      score_right <= score_right_nxt;
      timer       <= timer_nxt;
      d_inc       <= d_inc_nxt;
      d_clr       <= d_clr_nxt;
      ball_reset  <= ball_reset_nxt;
      game_over   <= game_over_nxt;
      winner      <= winner_nxt;
    end
  end

endmodule

// File: doc/pong_score_ctrl.md
PONG_SCORE_CTRL -- requirements
Module: pong_score_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 11, points that win a game; legal range 1..99.
REQ-002 Parameter SERVE_DELAY, default 50_000_000, clk cycles that the ball is held before each serve; legal range 2..2^26-1.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 btn_start  in  1  start/restart request, already synchronised and debounced, level.
REQ-006 miss_left  in  1  ball crossed the left boundary (right player scores), level.
REQ-007 miss_right  in  1  ball crossed the right boundary (left player scores), level.
REQ-008 d_inc  out  2  score increment to the downstream score counter: 01 = left player (digits 1:0), 10 = right player (digits 3:2), 00 = none.
REQ-009 d_clr  out  1  one-cycle clear pulse to the downstream score counter.
REQ-010 ball_reset  out  1  holds the ball and paddles at their serve positions.
REQ-011 game_over  out  1  high while a finished game is displayed.
REQ-012 winner  out  2  01 = left player won, 10 = right player won, 00 = no winner; valid while game_over is high.

Function
REQ-013 The FSM SHALL have the states IDLE, SERVE, PLAY, POINT and OVER.
REQ-014 start_rise SHALL be btn_start high while the registered previous value of btn_start is low.
REQ-015 IDLE: ball_reset=1; on start_rise, assert d_clr for the next cycle, clear both internal scores, and go to SERVE.
REQ-016 SERVE: ball_reset=1; the serve timer loads 0 on entry and increments each cycle; at SERVE_DELAY-1, go to PLAY; miss inputs are ignored.
REQ-017 PLAY: ball_reset=0; miss_right alone → POINT crediting left; miss_left alone → POINT crediting right.
REQ-018 PLAY: miss_left and miss_right high in the same cycle → no point; go to SERVE (replay).
REQ-019 POINT SHALL last exactly one cycle, with d_inc set to the credited code and the credited internal score incremented.
REQ-020 POINT exit: if the new score equals WIN_SCORE, go to OVER and latch winner; otherwise go to SERVE.
REQ-021 Latency: a miss sampled at edge N SHALL give d_inc != 00 during cycle N+1 only; each miss event yields exactly one pulse.
REQ-022 OVER: game_over=1, ball_reset=1, winner held; on start_rise, assert a d_clr pulse, clear the scores and winner, and go to SERVE.
REQ-023 start_rise in SERVE, PLAY or POINT SHALL be ignored.
REQ-024 d_inc and d_clr SHALL never be non-zero in the same cycle; all outputs are registered.
REQ-025 Internal scores SHALL be 7-bit unsigned and SHALL never exceed WIN_SCORE.

Reset
REQ-026 On reset: state=IDLE, d_inc=00, d_clr=0, ball_reset=1, game_over=0, winner=00, scores=0, timer=0, and the btn_start history register=1 so that a button held through reset does not start a game.
REQ-027 Reset asserted mid-game (any state) SHALL take effect at the next edge, with no d_inc or d_clr pulse emitted.

Structure
REQ-028 Package pong_pkg SHALL hold the state enumeration, the d_inc codes (INC_NONE, INC_LEFT, INC_RIGHT), and the WIN_SCORE and SERVE_DELAY defaults.
REQ-029 The btn_start rising-edge detector SHALL be a sub-module, rise_detect, with a reset-value parameter.
REQ-030 Target size: 120-400 lines of RTL.

Verification (WIN_SCORE=3, SERVE_DELAY=4)
REQ-031 Reset, then btn_start high for 1 cycle → d_clr=1 for exactly 1 cycle; ball_reset falls 4 cycles after entering SERVE.
REQ-032 In PLAY, miss_right pulse at edge N → d_inc=01 in cycle N+1 only, then SERVE; miss_left gives d_inc=10 in the same way.
REQ-033 miss_left and miss_right high together in PLAY → d_inc stays 00; FSM returns to SERVE.
REQ-034 Three left points → third d_inc=01, then game_over=1, winner=01; further misses produce no d_inc.
REQ-035 In OVER, btn_start → d_clr pulse, winner=00, game_over=0, a new serve; reset asserted during PLAY → IDLE with no pulses.
REQ-036 btn_start held through reset release → no start until it is released and pressed again.
